mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side responder for the cache_control_if protocol. It serves one CPU's icache and dcache requests against a single-ported RAM.
- It arbitrates instruction fetches against data reads and writes, and holds a grant until RAM completes.
- It drives iwait/dwait and the load buses back to the caches.
- It sits between the caches block and the RAM model, in place of a pure combinational memory controller.

Parameters:
- ADDR_W, 32, byte address width (word_t width).
- DATA_W, 32, data word width.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset; asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request (dREN and dWEN are never both high).
- daddr  in  ADDR_W  dcache address.
- dstore  in  DATA_W  dcache write data.
- iwait  out  1  high unless the icache transfer completes this cycle.
- dwait  out  1  high unless the dcache transfer completes this cycle.
- iload  out  DATA_W  instruction data.
- dload  out  DATA_W  read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- memerr  out  1  sticky flag: RAM returned ERROR.

Behaviour:
- FSM states: IDLE, DGRANT, IGRANT. The state is registered; all outputs are combinational from state and inputs.
- Reset (async, nRST low):
  - state=IDLE, last_d=0, memerr=0.
  - Outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iload and dload mirror ramload at all times.
- IDLE:
  - No RAM strobes; iwait=dwait=1.
  - Next state:
    - d request (dREN|dWEN) and no i request → DGRANT.
    - i request only → IGRANT.
    - Both requests: last_d=0 → DGRANT; last_d=1 → IGRANT. Data wins by default, and the two strictly alternate under contention (no starvation).
  - Consequence: minimum latency is 2 cycles from request to wait low (1 arbitration cycle + 1 ACCESS cycle).
- DGRANT:
  - Drives ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN. ramstore is driven for reads too (don't-care to RAM).
  - ramstate==ACCESS → dwait=0 for exactly that cycle; last_d<=1; next state IDLE.
  - BUSY or FREE → dwait=1; stay.
  - ERROR → dwait=1; memerr<=1; stay, so RAM retries.
  - Abort: dREN|dWEN drops while granted → IDLE next cycle, no completion pulse, last_d unchanged.
- IGRANT:
  - Drives ramaddr=iaddr, ramREN=1, ramWEN=0.
  - ramstate==ACCESS → iwait=0 for one cycle; last_d<=0; next state IDLE.
  - ERROR, abort and busy handling identical to DGRANT.
- The non-granted side always sees wait=1.
- Address or data changing mid-grant: passed through as-is; the caches hold them stable, and this block does not latch them.
- Back-to-back requests: after a completion the FSM returns to IDLE for one cycle, so throughput is at most one transfer per 2 cycles plus RAM latency.
- ACCESS in IDLE: ignored.
- memerr clears only on reset.
- Mid-transfer reset: everything returns immediately to reset values and the RAM strobes drop asynchronously.

Decomposition:
- Use the existing cpu_types_pkg: word_t, ramstate_t (FREE, BUSY, ACCESS, ERROR).
- Add arb_state_t {IDLE, DGRANT, IGRANT} to cpu_types_pkg so benches can probe the FSM state.
- No sub-module is needed: one FSM process plus one output-decode process.

Test Plan:
1. Reset, then iREN=1, iaddr=0x0000_0040, RAM answers ACCESS 2 cycles after the strobe with ramload=0x2001_0005.
   - ramREN=1, ramaddr=0x40 from cycle 1.
   - iwait=0 only in the ACCESS cycle, with iload=0x2001_0005.
   - Back in IDLE the next cycle.
2. dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF, immediate ACCESS.
   - ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF.
   - dwait low one cycle; iwait stays 1.
3. iREN and dREN held high continuously, 1-cycle RAM.
   - Grant order D, I, D, I.
   - Each side completes every 4 cycles; neither starves.
4. ramstate=ERROR for 3 cycles, then ACCESS during DGRANT.
   - dwait stays 1 through the errors, memerr=1 from the first ERROR.
   - Completion pulse on ACCESS; memerr stays 1.
5. dREN dropped while DGRANT and BUSY.
   - FSM goes to IDLE next cycle with no dwait=0 pulse.
   - A pending iREN is granted the following cycle.
6. nRST asserted mid-IGRANT (asynchronously, between clock edges).
   - ramREN=0 and iwait=1 immediately; state=IDLE; memerr=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter, bundled as one bus.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              memerr;

  // Arbiter (memory-side responder) view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  // Caches + RAM model view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches against dcache reads/writes onto one RAM port;
// a grant is held until the RAM reports ACCESS, contention alternates sides.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              last_d;
  logic              memerr_q;
  logic              d_req, i_req;
  logic              d_done, i_done, err_seen;
  logic              iwait_c, dwait_c, ram_ren, ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;

  assign d_req = bus.dREN | bus.dWEN;
  assign i_req = bus.iREN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d   <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (d_done)      last_d <= 1'b1;
      else if (i_done) last_d <= 1'b0;
      if (err_seen)    memerr_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    iwait_c   = 1'b1;
    dwait_c   = 1'b1;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    d_done    = 1'b0;
    i_done    = 1'b0;
    err_seen  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_d flips the tie-break after each completion so neither side starves
        if (d_req && (!i_req || !last_d)) state_d = DGRANT;
        else if (i_req)                   state_d = IGRANT;
      end
      DGRANT: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        ram_ren   = bus.dREN;
        ram_wen   = bus.dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          dwait_c = 1'b0;
          d_done  = 1'b1;
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          err_seen = 1'b1;
        end
      end
      IGRANT: begin
        ram_addr = bus.iaddr;
        ram_ren  = 1'b1;
        if (!i_req) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          iwait_c = 1'b0;
          i_done  = 1'b1;
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          err_seen = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.iwait    = iwait_c;
  assign bus.dwait    = dwait_c;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.memerr   = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: single grants, contention,
// RAM errors, aborted requests and asynchronous reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk;
  logic nrst;
  int   vectors;
  int   miscompares;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit (got hang, need finish)");
    $fatal(1, "timeout");
  end

  // Drive point: just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0;
    clear_inputs();
    bus.dWEN    = 1'b1;
    bus.daddr   = 32'h0000_0055;
    bus.dstore  = 32'h0000_0066;
    bus.ramload = 32'h1234_5678;
    #2;
    vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d need=%0d", dut.state_q, IDLE); end
    vectors++; if (bus.iwait !== 1'b1) begin miscompares++; $display("FAIL reset_iwait got=%b need=1", bus.iwait); end
    vectors++; if (bus.dwait !== 1'b1) begin miscompares++; $display("FAIL reset_dwait got=%b need=1", bus.dwait); end
    vectors++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin miscompares++; $display("FAIL reset_strobes got=%b%b need=00", bus.ramREN, bus.ramWEN); end
    vectors++; if (bus.ramaddr !== 32'h0) begin miscompares++; $display("FAIL reset_ramaddr got=%h need=0", bus.ramaddr); end
    vectors++; if (bus.ramstore !== 32'h0) begin miscompares++; $display("FAIL reset_ramstore got=%h need=0", bus.ramstore); end
    vectors++; if (bus.memerr !== 1'b0) begin miscompares++; $display("FAIL reset_memerr got=%b need=0", bus.memerr); end
    vectors++; if (bus.iload !== 32'h1234_5678 || bus.dload !== 32'h1234_5678) begin miscompares++; $display("FAIL reset_loads got=%h/%h need=12345678", bus.iload, bus.dload); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_ifetch();
    cyc(); bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040; bus.ramstate = FREE;
    mid();
    vectors++; if (dut.state_q !== IDLE || bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL if_arb got=%0d/%b need=IDLE/0", dut.state_q, bus.ramREN); end
    cyc(); bus.ramstate = BUSY;
    mid();
    vectors++; if (dut.state_q !== IGRANT) begin miscompares++; $display("FAIL if_grant got=%0d need=%0d", dut.state_q, IGRANT); end
    vectors++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin miscompares++; $display("FAIL if_strobe got=%b/%h need=1/40", bus.ramREN, bus.ramaddr); end
    vectors++; if (bus.iwait !== 1'b1) begin miscompares++; $display("FAIL if_busy1 got=%b need=1", bus.iwait); end
    cyc();
    mid();
    vectors++; if (bus.iwait !== 1'b1) begin miscompares++; $display("FAIL if_busy2 got=%b need=1", bus.iwait); end
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h2001_0005;
    mid();
    vectors++; if (bus.iwait !== 1'b0 || bus.dwait !== 1'b1) begin miscompares++; $display("FAIL if_done got=i%b d%b need=i0 d1", bus.iwait, bus.dwait); end
    vectors++; if (bus.iload !== 32'h2001_0005) begin miscompares++; $display("FAIL if_iload got=%h need=20010005", bus.iload); end
    cyc(); bus.iREN = 1'b0; bus.ramstate = FREE;
    mid();
    vectors++; if (dut.state_q !== IDLE || bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL if_back_idle got=%0d/%b/%b need=IDLE/1/0", dut.state_q, bus.iwait, bus.ramREN); end
  endtask

  task automatic test_dwrite();
    cyc(); bus.dWEN = 1'b1; bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
    mid();
    vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL dw_arb got=%0d need=IDLE", dut.state_q); end
    cyc(); bus.ramstate = ACCESS;
    mid();
    vectors++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL dw_strobes got=%b%b need=REN0 WEN1", bus.ramREN, bus.ramWEN); end
    vectors++; if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL dw_bus got=%h/%h need=100/deadbeef", bus.ramaddr, bus.ramstore); end
    vectors++; if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin miscompares++; $display("FAIL dw_done got=d%b i%b need=d0 i1", bus.dwait, bus.iwait); end
    cyc(); bus.dWEN = 1'b0; bus.ramstate = FREE;
    mid();
    vectors++; if (dut.state_q !== IDLE || bus.dwait !== 1'b1) begin miscompares++; $display("FAIL dw_back_idle got=%0d/%b need=IDLE/1", dut.state_q, bus.dwait); end
  endtask

  task automatic test_back_to_back();
    arb_state_t exp_st [9];
    exp_st = '{IDLE, DGRANT, IDLE, IGRANT, IDLE, DGRANT, IDLE, IGRANT, IDLE};
    test_reset();
    cyc(); bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h80; bus.daddr = 32'h300; bus.ramstate = ACCESS;
    mid();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin cyc(); mid(); end
      vectors++; if (dut.state_q !== exp_st[k]) begin miscompares++; $display("FAIL b2b_state[%0d] got=%0d need=%0d", k, dut.state_q, exp_st[k]); end
      vectors++; if (bus.dwait !== (exp_st[k] != DGRANT) || bus.iwait !== (exp_st[k] != IGRANT)) begin miscompares++; $display("FAIL b2b_wait[%0d] got=d%b i%b need=d%b i%b", k, bus.dwait, bus.iwait, exp_st[k] != DGRANT, exp_st[k] != IGRANT); end
    end
    cyc(); bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    cyc();
  endtask

  task automatic test_error();
    test_reset();
    cyc(); bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = FREE;
    mid();
    vectors++; if (dut.state_q !== IDLE || bus.memerr !== 1'b0) begin miscompares++; $display("FAIL err_arb got=%0d/%b need=IDLE/0", dut.state_q, bus.memerr); end
    cyc(); bus.ramstate = ERROR;
    mid();
    vectors++; if (dut.state_q !== DGRANT || bus.dwait !== 1'b1) begin miscompares++; $display("FAIL err_c1 got=%0d/%b need=DGRANT/1", dut.state_q, bus.dwait); end
    for (int k = 0; k < 2; k++) begin
      cyc(); mid();
      vectors++; if (bus.dwait !== 1'b1 || bus.memerr !== 1'b1 || dut.state_q !== DGRANT) begin miscompares++; $display("FAIL err_hold[%0d] got=%b/%b/%0d need=1/1/DGRANT", k, bus.dwait, bus.memerr, dut.state_q); end
    end
    cyc(); bus.ramstate = ACCESS;
    mid();
    vectors++; if (bus.dwait !== 1'b0 || bus.memerr !== 1'b1) begin miscompares++; $display("FAIL err_done got=%b/%b need=0/1", bus.dwait, bus.memerr); end
    cyc(); bus.dREN = 1'b0; bus.ramstate = FREE;
    mid();
    vectors++; if (dut.state_q !== IDLE || bus.memerr !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%0d/%b need=IDLE/1", dut.state_q, bus.memerr); end
  endtask

  task automatic test_abort();
    cyc(); bus.dREN = 1'b1; bus.daddr = 32'h400;
    mid();
    cyc(); bus.ramstate = BUSY;
    mid();
    vectors++; if (dut.state_q !== DGRANT || bus.ramREN !== 1'b1 || bus.dwait !== 1'b1) begin miscompares++; $display("FAIL ab_grant got=%0d/%b/%b need=DGRANT/1/1", dut.state_q, bus.ramREN, bus.dwait); end
    cyc(); bus.dREN = 1'b0; bus.iREN = 1'b1; bus.iaddr = 32'h500;
    mid();
    vectors++; if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL ab_drop got=%b/%b need=1/0", bus.dwait, bus.ramREN); end
    cyc();
    mid();
    vectors++; if (dut.state_q !== IDLE || bus.dwait !== 1'b1 || bus.iwait !== 1'b1) begin miscompares++; $display("FAIL ab_idle got=%0d/%b/%b need=IDLE/1/1", dut.state_q, bus.dwait, bus.iwait); end
    cyc();
    mid();
    vectors++; if (dut.state_q !== IGRANT || bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h500) begin miscompares++; $display("FAIL ab_igrant got=%0d/%b/%h need=IGRANT/1/500", dut.state_q, bus.ramREN, bus.ramaddr); end
  endtask

  task automatic test_async_reset();
    vectors++; if (bus.memerr !== 1'b1 || dut.state_q !== IGRANT) begin miscompares++; $display("FAIL ar_pre got=%b/%0d need=1/IGRANT", bus.memerr, dut.state_q); end
    #2;
    nrst = 1'b0;
    #1;
    vectors++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin miscompares++; $display("FAIL ar_outputs got=%b/%b need=0/1", bus.ramREN, bus.iwait); end
    vectors++; if (dut.state_q !== IDLE || bus.memerr !== 1'b0) begin miscompares++; $display("FAIL ar_state got=%0d/%b need=IDLE/0", dut.state_q, bus.memerr); end
    clear_inputs();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nrst        = 1'b0;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_dwrite();
    test_back_to_back();
    test_error();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
